pcs_lane_channel_emulator: RTL

Synthesizable multi-lane channel model that sits between the TX PCS lane output and the RX PCS lane input in loopback builds. It replaces the direct TX-to-RX wire. It applies per-lane skew, measured in valid blocks, and a programmable lane permutation. It also injects periodic bit errors, so block sync, alignment, deskew and lane reorder can be exercised on-chip without an external channel.

---
 rtl/pcs_lane_channel_emulator.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pcs_lane_channel_emulator.sv
// pcs_lane_channel_emulator
// Loopback channel model placed between TX PCS lane outputs and RX PCS lane
// inputs. Applies per-lane block skew, lane permutation and periodic error
// injection so that RX sync/deskew/reorder logic can be exercised on-chip.
//
// Ports:
//   i_clock, i_reset_n       clock, async active-low reset
//   i_valid, i_data          TX block strobe and lane bus (lane k at k*NB_DATA)
//   i_rf_enable              0 = transparent bypass, 1 = emulate
//   i_rf_load                pulse: capture skew and lane map into shadow regs
//   i_rf_skew_bus            per-output-lane delay in valid blocks
//   i_rf_lane_map            output lane k sources input lane map[k]
//   i_rf_err_period          valid blocks between injections, 0 = off (live)
//   i_rf_err_mask            XOR pattern for injection (live)
//   i_rf_err_lane_mask       output lanes that receive injection (live)
//   o_valid, o_data          impaired block strobe and lane bus
//   o_err_count              saturating count of injection events
//   o_cfg_busy               high while the delay lines refill
//
// state  | meaning
// BYPASS | i_data/i_valid passed through with one register stage
// FILL   | delay lines refilling after enable/load, output strobe held off
// RUN    | skew, lane map and error injection applied
module pcs_lane_channel_emulator #(
    parameter int N_LANES        = 20,
    parameter int NB_DATA        = 66,
    parameter int MAX_SKEW       = 16,
    parameter int NB_SKEW        = $clog2(MAX_SKEW),
    parameter int NB_LANE_ID     = $clog2(N_LANES),
    parameter int NB_ERR_PERIOD  = 16,
    parameter int NB_ERR_COUNTER = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [N_LANES*NB_DATA-1:0]    i_data,
    input  logic                          i_rf_enable,
    input  logic                          i_rf_load,
    input  logic [N_LANES*NB_SKEW-1:0]    i_rf_skew_bus,
    input  logic [N_LANES*NB_LANE_ID-1:0] i_rf_lane_map,
    input  logic [NB_ERR_PERIOD-1:0]      i_rf_err_period,
    input  logic [NB_DATA-1:0]            i_rf_err_mask,
    input  logic [N_LANES-1:0]            i_rf_err_lane_mask,
    output logic                          o_valid,
    output logic [N_LANES*NB_DATA-1:0]    o_data,
    output logic [NB_ERR_COUNTER-1:0]     o_err_count,
    output logic                          o_cfg_busy
);

    typedef enum logic [1:0] {ST_BYPASS, ST_FILL, ST_RUN} state_t;

    localparam logic [NB_SKEW:0]   DEPTH     = (NB_SKEW+1)'(MAX_SKEW);
    localparam logic [NB_SKEW-1:0] SKEW_MAX  = NB_SKEW'(MAX_SKEW - 1);
    localparam logic [NB_SKEW-1:0] FILL_LAST = NB_SKEW'(MAX_SKEW - 2);

    function automatic logic [N_LANES*NB_LANE_ID-1:0] identity_map();
        logic [N_LANES*NB_LANE_ID-1:0] m;
        m = '0;
        for (int k = 0; k < N_LANES; k++) m[k*NB_LANE_ID +: NB_LANE_ID] = NB_LANE_ID'(k);
        return m;
    endfunction

    localparam logic [N_LANES*NB_LANE_ID-1:0] MAP_RESET = identity_map();

    state_t                          state_q;
    logic [NB_SKEW-1:0]              wr_ptr_q;
    logic [NB_SKEW-1:0]              fill_cnt_q;
    logic [NB_ERR_PERIOD-1:0]        phase_q;
    logic [NB_ERR_COUNTER-1:0]       err_cnt_q;
    logic [N_LANES*NB_SKEW-1:0]      skew_q;
    logic [N_LANES*NB_LANE_ID-1:0]   map_q;
    logic                            o_valid_q;
    logic [N_LANES*NB_DATA-1:0]      o_data_q;
    logic [NB_DATA-1:0]              mem_q [N_LANES][MAX_SKEW];

    logic [N_LANES*NB_DATA-1:0]      run_data_d;
    logic                            inject_d;

    // Delay line: one shared write pointer, written on every valid block in
    // all states so the lines are already warm when FILL begins.
    always_ff @(posedge i_clock) begin
        if (i_valid) begin
            for (int k = 0; k < N_LANES; k++)
                mem_q[k][wr_ptr_q] <= i_data[k*NB_DATA +: NB_DATA];
        end
    end

    always_comb begin
        run_data_d = '0;
        inject_d   = (i_rf_err_period != '0) &&
                     (phase_q == i_rf_err_period - NB_ERR_PERIOD'(1));
        for (int k = 0; k < N_LANES; k++) begin
            logic [NB_SKEW-1:0]    s;
            logic [NB_LANE_ID-1:0] m;
            logic [NB_SKEW:0]      idx;
            logic [NB_DATA-1:0]    lane;
            s = skew_q[k*NB_SKEW +: NB_SKEW];
            if (s > SKEW_MAX) s = SKEW_MAX;
            m   = map_q[k*NB_LANE_ID +: NB_LANE_ID];
            idx = {1'b0, wr_ptr_q} + DEPTH - {1'b0, s};
            if (idx >= DEPTH) idx = idx - DEPTH;
            lane = '0;
            if (int'(m) < N_LANES) begin
                // Skew 0 means the block arriving this cycle, not yet in memory.
                if (s == '0) lane = i_data[int'(m)*NB_DATA +: NB_DATA];
                else         lane = mem_q[m][idx[NB_SKEW-1:0]];
            end
            if (inject_d && i_rf_err_lane_mask[k]) lane = lane ^ i_rf_err_mask;
            run_data_d[k*NB_DATA +: NB_DATA] = lane;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_BYPASS;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            phase_q    <= '0;
            err_cnt_q  <= '0;
            skew_q     <= '0;
            map_q      <= MAP_RESET;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
        end else begin
            if (i_rf_load) begin
                skew_q <= i_rf_skew_bus;
                map_q  <= i_rf_lane_map;
            end
            if (i_valid) wr_ptr_q <= (wr_ptr_q == SKEW_MAX) ? '0 : wr_ptr_q + 1'b1;

            // Output stage driven by the current state.
            case (state_q)
                ST_BYPASS: begin
                    o_valid_q <= i_valid;
                    o_data_q  <= i_data;
                end
                ST_FILL: o_valid_q <= 1'b0;
                ST_RUN: begin
                    o_valid_q <= i_valid;
                    if (i_valid) begin
                        o_data_q <= run_data_d;
                        if (inject_d) begin
                            phase_q <= '0;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                default: o_valid_q <= 1'b0;
            endcase

            // Transitions; the phase clear on FILL entry overrides the
            // injection bookkeeping above, which has already taken effect.
            if (!i_rf_enable) begin
                state_q <= ST_BYPASS;
            end else begin
                case (state_q)
                    ST_BYPASS: begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= '0;
                        phase_q    <= '0;
                        skew_q     <= i_rf_skew_bus;
                        map_q      <= i_rf_lane_map;
                    end
                    ST_FILL: begin
                        if (i_rf_load) begin
                            fill_cnt_q <= '0;
                        end else if (i_valid) begin
                            if (fill_cnt_q == FILL_LAST) state_q <= ST_RUN;
                            else                         fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (i_rf_load) begin
                            state_q    <= ST_FILL;
                            fill_cnt_q <= '0;
                            phase_q    <= '0;
                        end
                    end
                    default: state_q <= ST_BYPASS;
                endcase
            end
        end
    end

    assign o_valid     = o_valid_q;
    assign o_data      = o_data_q;
    assign o_err_count = err_cnt_q;
    assign o_cfg_busy  = (state_q == ST_FILL);

endmodule
